// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus responder: phase enum, command
// decode masks, DDRAM line bounds and the two-line cursor step helper.
package lcd_pkg;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_t;

    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_HOME       = 8'h02;
    localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
    localparam logic [7:0] CMD_ENTRY      = 8'h04;
    localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
    localparam logic [7:0] CMD_FUNC       = 8'h20;
    localparam logic [7:0] CMD_FUNC_MASK  = 8'hE0;
    localparam logic [7:0] CMD_SETDD_MASK = 8'h80;

    localparam logic [6:0] L1_LAST  = 7'h27;
    localparam logic [6:0] L2_FIRST = 7'h40;
    localparam logic [6:0] L2_LAST  = 7'h67;

    // Addresses outside both lines simply count, matching the LCD's own behaviour.
    function automatic logic [6:0] cursor_step(input logic [6:0] addr, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (addr == L1_LAST)      nxt = L2_FIRST;
            else if (addr == L2_LAST) nxt = 7'h00;
            else                      nxt = addr + 7'h01;
        end else begin
            if (addr == 7'h00)         nxt = L2_LAST;
            else if (addr == L2_FIRST) nxt = L1_LAST;
            else                       nxt = addr - 7'h01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Synchronises the asynchronous LCD bus into clk and flags the falling edge of E,
// presenting the data/RS/RW that were synchronised alongside that edge.
module lcd_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    output logic       e_fall,
    output logic [3:0] bus_data,
    output logic       bus_rs,
    output logic       bus_rw
);

    logic [6:0] sync_q [SYNC_STAGES];
    logic       e_prev;

    // Whole bus travels through the same stages so data stays aligned with E.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            e_prev <= 1'b0;
        end else begin
            sync_q[0] <= {lcd_e, lcd_rw, lcd_rs, lcd_data};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            e_prev <= sync_q[SYNC_STAGES-1][6];
        end
    end

    assign e_fall   = e_prev & ~sync_q[SYNC_STAGES-1][6];
    assign bus_rw   = sync_q[SYNC_STAGES-1][5];
    assign bus_rs   = sync_q[SYNC_STAGES-1][4];
    assign bus_data = sync_q[SYNC_STAGES-1][3:0];

endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-compatible bus responder: reassembles nibbles, decodes commands and tracks the cursor.
// Optional busy/timing-violation model enabled by defining LCD_BUSY_MODEL_EN.
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned BUSY_CYCLES       = 2000,
    parameter int unsigned CLEAR_BUSY_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_e,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       byte_rs,
    output logic       mode4,
    output logic       char_we,
    output logic [6:0] char_addr,
    output logic [7:0] char_data,
    output logic       cmd_clear,
    output logic       proto_err,
    output logic       timing_err
);

    localparam int unsigned BUSY_MAX =
        (CLEAR_BUSY_CYCLES > BUSY_CYCLES) ? CLEAR_BUSY_CYCLES : BUSY_CYCLES;
    typedef logic [$clog2(BUSY_MAX + 1)-1:0] busy_cnt_t;

    logic       e_fall;
    logic [3:0] bus_data;
    logic       bus_rs;
    logic       bus_rw;

    lcd_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .e_fall   (e_fall),
        .bus_data (bus_data),
        .bus_rs   (bus_rs),
        .bus_rw   (bus_rw)
    );

    phase_t     phase, phase_nxt;
    logic       mode4_nxt;
    logic [6:0] cursor, cursor_nxt;
    logic       inc, inc_nxt;
    logic [3:0] hi_nib, hi_nib_nxt;
    logic       hi_rs, hi_rs_nxt;

    logic       done;
    logic [7:0] asm_byte;
    logic       asm_rs;

    logic       byte_valid_nxt;
    logic [7:0] byte_out_nxt;
    logic       byte_rs_nxt;
    logic       char_we_nxt;
    logic [6:0] char_addr_nxt;
    logic [7:0] char_data_nxt;
    logic       cmd_clear_nxt;
    logic       proto_err_nxt;

    // Assembly and decode resolve together so the cursor step is atomic with the write.
    always_comb begin
        phase_nxt      = phase;
        mode4_nxt      = mode4;
        cursor_nxt     = cursor;
        inc_nxt        = inc;
        hi_nib_nxt     = hi_nib;
        hi_rs_nxt      = hi_rs;
        done           = 1'b0;
        asm_byte       = 8'h00;
        asm_rs         = 1'b0;
        byte_valid_nxt = 1'b0;
        byte_out_nxt   = byte_out;
        byte_rs_nxt    = byte_rs;
        char_we_nxt    = 1'b0;
        char_addr_nxt  = char_addr;
        char_data_nxt  = char_data;
        cmd_clear_nxt  = 1'b0;
        proto_err_nxt  = 1'b0;

        if (e_fall) begin
            if (!mode4) begin
                if (!bus_rw) begin
                    done     = 1'b1;
                    asm_byte = {bus_data, 4'h0};
                    asm_rs   = bus_rs;
                end
            end else if (phase == PH_HI) begin
                phase_nxt  = PH_LO;
                hi_nib_nxt = bus_data;
                hi_rs_nxt  = bus_rs;
            end else begin
                phase_nxt = PH_HI;
                if (!bus_rw) begin
                    done          = 1'b1;
                    asm_byte      = {hi_nib, bus_data};
                    asm_rs        = hi_rs;
                    proto_err_nxt = (bus_rs != hi_rs);
                end
            end
        end

        if (done) begin
            byte_valid_nxt = 1'b1;
            byte_out_nxt   = asm_byte;
            byte_rs_nxt    = asm_rs;
            if (asm_rs) begin
                char_we_nxt   = 1'b1;
                char_addr_nxt = cursor;
                char_data_nxt = asm_byte;
                cursor_nxt    = cursor_step(cursor, inc);
            end else if (asm_byte == CMD_CLEAR) begin
                cmd_clear_nxt = 1'b1;
                cursor_nxt    = 7'h00;
                inc_nxt       = 1'b1;
            end else if ((asm_byte & CMD_HOME_MASK) == CMD_HOME) begin
                cursor_nxt = 7'h00;
            end else if ((asm_byte & CMD_ENTRY_MASK) == CMD_ENTRY) begin
                inc_nxt = asm_byte[1];
            end else if ((asm_byte & CMD_SETDD_MASK) != 8'h00) begin
                cursor_nxt = asm_byte[6:0];
            end else if ((asm_byte & CMD_FUNC_MASK) == CMD_FUNC) begin
                if (!mode4 && !asm_byte[4]) begin
                    mode4_nxt = 1'b1;
                    phase_nxt = PH_HI;
                end else if (mode4 && asm_byte[4]) begin
                    mode4_nxt = 1'b0;
                    phase_nxt = PH_HI;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase      <= PH_HI;
            mode4      <= 1'b0;
            cursor     <= 7'h00;
            inc        <= 1'b1;
            hi_nib     <= 4'h0;
            hi_rs      <= 1'b0;
            byte_valid <= 1'b0;
            byte_out   <= 8'h00;
            byte_rs    <= 1'b0;
            char_we    <= 1'b0;
            char_addr  <= 7'h00;
            char_data  <= 8'h00;
            cmd_clear  <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            phase      <= phase_nxt;
            mode4      <= mode4_nxt;
            cursor     <= cursor_nxt;
            inc        <= inc_nxt;
            hi_nib     <= hi_nib_nxt;
            hi_rs      <= hi_rs_nxt;
            byte_valid <= byte_valid_nxt;
            byte_out   <= byte_out_nxt;
            byte_rs    <= byte_rs_nxt;
            char_we    <= char_we_nxt;
            char_addr  <= char_addr_nxt;
            char_data  <= char_data_nxt;
            cmd_clear  <= cmd_clear_nxt;
            proto_err  <= proto_err_nxt;
        end
    end

`ifdef LCD_BUSY_MODEL_EN
    busy_cnt_t busy_cnt, busy_nxt;
    logic      long_cmd;

    // 8-bit init bytes never load the counter; the driver owns those delays.
    always_comb begin
        long_cmd = !asm_rs && ((asm_byte == CMD_CLEAR) ||
                               ((asm_byte & CMD_HOME_MASK) == CMD_HOME));
        busy_nxt = busy_cnt;
        if (done && mode4) begin
            busy_nxt = long_cmd ? busy_cnt_t'(CLEAR_BUSY_CYCLES) : busy_cnt_t'(BUSY_CYCLES);
        end else if (busy_cnt != '0) begin
            busy_nxt = busy_cnt - busy_cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt   <= '0;
            timing_err <= 1'b0;
        end else begin
            busy_cnt   <= busy_nxt;
            timing_err <= e_fall && !bus_rw && (busy_cnt != '0);
        end
    end
`else
    assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: expected bytes are queued as stimulus is
// driven and checked by a negedge monitor whenever byte_valid fires.
module tb_lcd_bus_responder;

    logic       clk;
    logic       reset;
    logic [3:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       byte_valid;
    logic [7:0] byte_out;
    logic       byte_rs;
    logic       mode4;
    logic       char_we;
    logic [6:0] char_addr;
    logic [7:0] char_data;
    logic       cmd_clear;
    logic       proto_err;
    logic       timing_err;

    lcd_bus_responder #(
        .SYNC_STAGES       (2),
        .BUSY_CYCLES       (10),
        .CLEAR_BUSY_CYCLES (40)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_e      (lcd_e),
        .byte_valid (byte_valid),
        .byte_out   (byte_out),
        .byte_rs    (byte_rs),
        .mode4      (mode4),
        .char_we    (char_we),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .cmd_clear  (cmd_clear),
        .proto_err  (proto_err),
        .timing_err (timing_err)
    );

`ifdef LCD_BUSY_MODEL_EN
    localparam int EXP_TIM_FIRST = 1;
    localparam int EXP_TIM_TOTAL = 2;
`else
    localparam int EXP_TIM_FIRST = 0;
    localparam int EXP_TIM_TOTAL = 0;
`endif

    typedef struct {
        logic [7:0] b;
        logic       rs;
        logic       we;
        logic [6:0] addr;
        logic       clr;
        logic       perr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tim_pulses = 0;
    int   proto_pulses = 0;
    logic bench_m4 = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (timing_err === 1'b1) tim_pulses++;
        if (proto_err === 1'b1) proto_pulses++;
        if (byte_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_byte", 32'(byte_out), 32'hFFFF);
            end else begin
                e = sb.pop_front();
                check("byte_out", 32'(byte_out), 32'(e.b));
                check("byte_rs", 32'(byte_rs), 32'(e.rs));
                check("char_we", 32'(char_we), 32'(e.we));
                check("cmd_clear", 32'(cmd_clear), 32'(e.clr));
                check("proto_err", 32'(proto_err), 32'(e.perr));
                if (e.we) begin
                    check("char_addr", 32'(char_addr), 32'(e.addr));
                    check("char_data", 32'(char_data), 32'(e.b));
                end
            end
        end
    end

    task automatic strobe(input logic [3:0] d, input logic rs, input logic rw);
        @(posedge clk); #1;
        lcd_data = d;
        lcd_rs   = rs;
        lcd_rw   = rw;
        @(posedge clk); #1;
        lcd_e = 1'b1;
        repeat (3) @(posedge clk);
        #1 lcd_e = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rs, input logic [6:0] addr,
                             input int gap);
        exp_t e;
        e.b    = bench_m4 ? b : {b[7:4], 4'h0};
        e.rs   = rs;
        e.we   = rs;
        e.addr = addr;
        e.clr  = !rs && (b == 8'h01);
        e.perr = 1'b0;
        sb.push_back(e);
        strobe(b[7:4], rs, 1'b0);
        if (bench_m4) strobe(b[3:0], rs, 1'b0);
        repeat (gap) @(posedge clk);
    endtask

    task automatic applyStimulus();
        exp_t e;
        // Reset state
        reset = 1'b0; lcd_data = 4'h0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_byte_valid", 32'(byte_valid), 0);
        check("rst_mode4", 32'(mode4), 0);
        check("rst_char_we", 32'(char_we), 0);
        check("rst_timing_err", 32'(timing_err), 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // 8-bit init then switch to 4-bit
        send_byte(8'h30, 1'b0, 7'h00, 2);
        send_byte(8'h30, 1'b0, 7'h00, 2);
        send_byte(8'h30, 1'b0, 7'h00, 2);
        check("mode4_before_fs", 32'(mode4), 0);
        send_byte(8'h20, 1'b0, 7'h00, 2);
        check("mode4_after_fs", 32'(mode4), 1);
        bench_m4 = 1'b1;

        // First character at home position, then auto-increment
        send_byte(8'h80, 1'b0, 7'h00, 15);
        send_byte(8'h48, 1'b1, 7'h00, 15);
        send_byte(8'h49, 1'b1, 7'h01, 15);

        // Line wrap boundaries
        send_byte(8'hA7, 1'b0, 7'h00, 15);
        send_byte(8'h41, 1'b1, 7'h27, 15);
        send_byte(8'h42, 1'b1, 7'h40, 15);
        send_byte(8'hE7, 1'b0, 7'h00, 15);
        send_byte(8'h43, 1'b1, 7'h67, 15);
        send_byte(8'h44, 1'b1, 7'h00, 15);

        // Decrement across the line boundary
        send_byte(8'h04, 1'b0, 7'h00, 15);
        send_byte(8'hC0, 1'b0, 7'h00, 15);
        send_byte(8'h45, 1'b1, 7'h40, 15);
        send_byte(8'h46, 1'b1, 7'h27, 15);
        send_byte(8'h06, 1'b0, 7'h00, 15);

        // Read strobes only advance phase
        strobe(4'h7, 1'b0, 1'b1);
        strobe(4'h7, 1'b0, 1'b1);
        repeat (15) @(posedge clk);
        check("no_byte_on_read", 32'(sb.size()), 0);

        // RS mismatch between nibbles
        e.b = 8'h5A; e.rs = 1'b1; e.we = 1'b1; e.addr = 7'h26; e.clr = 1'b0; e.perr = 1'b1;
        sb.push_back(e);
        strobe(4'h5, 1'b1, 1'b0);
        strobe(4'hA, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        check("proto_pulses", 32'(proto_pulses), 1);

        // Clear resets cursor
        send_byte(8'h01, 1'b0, 7'h00, 50);
        send_byte(8'h47, 1'b1, 7'h00, 15);
        check("tim_pulses_none", 32'(tim_pulses), 0);

        // Back-to-back bytes hit the busy window
        send_byte(8'h0C, 1'b0, 7'h00, 0);
        send_byte(8'h0C, 1'b0, 7'h00, 15);
        check("tim_pulses_busy", 32'(tim_pulses), 32'(EXP_TIM_FIRST));

        // Clear, then reset with a high nibble pending
        send_byte(8'h01, 1'b0, 7'h00, 0);
        strobe(4'h4, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        check("tim_pulses_clear", 32'(tim_pulses), 32'(EXP_TIM_TOTAL));
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_mode4", 32'(mode4), 0);
        check("midrst_char_we", 32'(char_we), 0);
        check("midrst_byte_out", 32'(byte_out), 0);
        reset = 1'b1;
        bench_m4 = 1'b0;
        repeat (2) @(posedge clk);
        send_byte(8'h30, 1'b0, 7'h00, 4);
        check("post_rst_mode4", 32'(mode4), 0);
    endtask

    task automatic checkOutput();
        repeat (10) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        check("tim_pulses_final", 32'(tim_pulses), 32'(EXP_TIM_TOTAL));
    endtask

    initial begin
        applyStimulus();
        checkOutput();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
